// File: rtl/strobe_dec_pkg.sv
// Shared types and constants for the 3-to-8 strobe decoder.
// Pure declarations; no logic, no latency, no flow control.
package strobe_dec_pkg;

    localparam int CODE_W = 3;
    localparam int LINES  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef logic [LINES-1:0] onehot_t;

endpackage

// File: rtl/onehot_dec3_8.sv
// Combinational 3-bit binary code to 8-bit one-hot mapping.
// Zero latency; no flow control, the caller registers the result.
module onehot_dec3_8
    import strobe_dec_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [LINES-1:0]  y
);

    always_comb begin
        y       = '0;
        y[code] = 1'b1;
    end

endmodule

// File: rtl/strobe_decoder3_8.sv
// Sequential 3-to-8 strobe decoder: drives one line for PULSE_LEN cycles, then holds y=0 for GAP_LEN cycles.
// Latency: y one cycle after accept; back-to-back period PULSE_LEN+GAP_LEN+1. Optional sweep: STROBE_SWEEP_EN.
// Backpressure: in_ready only in IDLE with en high; en low aborts the current strobe (or sweep) without done.
module strobe_decoder3_8
    import strobe_dec_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
`ifdef STROBE_SWEEP_EN
    input  logic              sweep_start,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code,
    output logic [LINES-1:0]  y,
    output logic              y_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [CODE_W-1:0] LAST_CODE  = CODE_W'(LINES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] next_code;
    onehot_t           dec_y;
    logic              sweep_go;
    logic              sweep_q;
    logic              sweep_more;
    logic              last_code;

    assign in_ready = (state == IDLE) && en;
    assign busy     = (state != IDLE);

`ifdef STROBE_SWEEP_EN
    assign sweep_go = sweep_start;

    // Sweep flag is captured on the IDLE accept and held until the next IDLE visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_q <= 1'b0;
        end else if (state == IDLE || !en) begin
            sweep_q <= in_ready && sweep_start;
        end
    end
`else
    assign sweep_go = 1'b0;
    assign sweep_q  = 1'b0;
`endif

    assign sweep_more = sweep_q && (code_q != LAST_CODE);
    assign next_code  = (state == IDLE) ? (sweep_go ? '0 : code) : code_q + 1'b1;
    assign last_code  = (next_code == LAST_CODE);

    onehot_dec3_8 u_dec (
        .code (next_code),
        .y    (dec_y)
    );

    // done is registered, so it is scheduled on the edge that enters the counter==0 DRIVE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            code_q  <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            done    <= 1'b0;
        end else if (!en) begin
            state   <= IDLE;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (in_valid || sweep_go) begin
                        state   <= DRIVE;
                        cnt     <= PULSE_LOAD;
                        code_q  <= next_code;
                        y       <= dec_y;
                        y_valid <= 1'b1;
                        done    <= (PULSE_LEN == 1) && !sweep_go;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        if (GAP_LEN > 0) begin
                            state   <= GAP;
                            cnt     <= GAP_LOAD;
                            y       <= '0;
                            y_valid <= 1'b0;
                            done    <= 1'b0;
                        end else if (sweep_more) begin
                            cnt     <= PULSE_LOAD;
                            code_q  <= next_code;
                            y       <= dec_y;
                            y_valid <= 1'b1;
                            done    <= (PULSE_LEN == 1) && last_code;
                        end else begin
                            state   <= IDLE;
                            y       <= '0;
                            y_valid <= 1'b0;
                            done    <= 1'b0;
                        end
                    end else begin
                        cnt  <= cnt - CNT_W'(1);
                        done <= (cnt == CNT_W'(1)) && (!sweep_q || code_q == LAST_CODE);
                    end
                end
                GAP: begin
                    done <= 1'b0;
                    if (cnt == '0) begin
                        if (sweep_more) begin
                            state   <= DRIVE;
                            cnt     <= PULSE_LOAD;
                            code_q  <= next_code;
                            y       <= dec_y;
                            y_valid <= 1'b1;
                            done    <= (PULSE_LEN == 1) && last_code;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    y       <= '0;
                    y_valid <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/strobe_decoder3_8.md
Name: strobe_decoder3_8

Overview:
Sequential 3-to-8 one-hot decoder, the inverse of the team's 8-to-3 encoder.
- Accepts a 3-bit code over a valid/ready handshake.
- Drives the matching one-hot line on y for a programmable number of cycles, then holds an inter-strobe gap.
- Sits between control logic and strobe/enable fan-out: row selects, chip selects, LED/mux select lines.

Parameters:
PULSE_LEN, 4, cycles the one-hot output is held per accepted code; legal range 1..255
GAP_LEN, 1, cycles y is forced to 0 after each strobe before the next accept; legal range 0..255
CNT_W, 8, width of the internal down-counter; must satisfy 2^CNT_W > max(PULSE_LEN, GAP_LEN)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; low aborts any strobe and blocks accepts
in_valid  input  1  code is valid this cycle
in_ready  output  1  block can accept a code this cycle
code  input  3  binary index of the line to strobe
y  output  8  one-hot strobe output, registered
y_valid  output  1  high exactly while y is non-zero, registered
busy  output  1  high in DRIVE or GAP
done  output  1  one-cycle pulse on the last DRIVE cycle of a completed strobe, registered

Behaviour:
- Reset (async assert, sync release): state=IDLE, y=0, y_valid=0, done=0, counter=0.
- Reset mid-strobe kills y immediately and asynchronously. No done is produced.
- in_ready = (state==IDLE) && en. It is combinational from the state register and en. in_valid does not feed in_ready.
- States: IDLE, DRIVE, GAP.
- IDLE:
  - y=0.
  - On accept (in_valid && in_ready at edge N): code is latched, and y=1<<code, y_valid=1 take effect after edge N.
  - Counter loads PULSE_LEN-1; next state is DRIVE.
  - Latency: one cycle from accept to y.
- DRIVE:
  - y is held constant; the counter decrements each cycle.
  - When counter==0 this cycle: done=1 this cycle.
  - Next state is GAP (counter=GAP_LEN-1) if GAP_LEN>0, else IDLE. y=0 and y_valid=0 after that edge.
  - y is therefore high for exactly PULSE_LEN cycles.
- GAP:
  - y=0; the counter decrements.
  - At counter==0, next state is IDLE.
- Strobe period for back-to-back codes is PULSE_LEN+GAP_LEN+1 cycles. The IDLE accept cycle always shows y=0, so at least one zero cycle separates strobes even when GAP_LEN=0.
- en low in DRIVE or GAP:
  - Next edge: state=IDLE, y=0, y_valid=0, no done.
  - The aborted code is discarded, not replayed.
- in_valid while busy is ignored (in_ready=0). Upstream must hold code and in_valid until accepted.
- code changes after accept do not affect y.
- y is always zero or exactly one-hot. y_valid == |y at all times.

Optional Feature:
STROBE_SWEEP_EN
- Defined:
  - Adds input port sweep_start (1 bit).
  - In IDLE with en=1, sweep_start=1 has priority over in_valid and starts a sweep.
  - A sweep strobes codes 0,1,...,7 in order, each with the normal DRIVE/GAP timing. The return to IDLE between codes is skipped: GAP (or DRIVE when GAP_LEN=0) goes directly to DRIVE with the next code.
  - in_ready stays 0 for the whole sweep.
  - done pulses only on the last DRIVE cycle of code 7.
  - en low aborts the whole sweep.
- Undefined:
  - sweep_start port and sweep logic are absent.
  - Behaviour is exactly as specified above.

Decomposition:
- Package strobe_dec_pkg holds:
  - CODE_W=3, LINES=8
  - typedef enum for state {IDLE, DRIVE, GAP}
  - typedef for the one-hot vector
- Sub-module onehot_dec3_8: purely combinational code-to-one-hot mapping, instantiated once. The top registers its output.

Test Plan:
- Reset/idle: rst_n low mid-DRIVE (code=5) -> y=0, y_valid=0 asynchronously. After release: in_ready=1 with en=1, done=0.
- Single strobe, PULSE_LEN=4, GAP_LEN=2: accept code=3 at edge N -> y=8'h08 for 4 cycles, done on the 4th, then y=0 for 2 GAP cycles plus 1 IDLE cycle. in_ready re-asserts on the 7th cycle after N.
- Back-to-back with GAP_LEN=0: codes 0 then 7 held valid -> y=8'h01 ×4, one cycle y=0, y=8'h80 ×4. Two done pulses.
- Backpressure: in_valid=1, code=2 during DRIVE -> in_ready=0 and no change to y. Code 2 is accepted in the next IDLE cycle.
- Abort: en dropped on the 2nd DRIVE cycle of code=6 -> next cycle y=0, state IDLE, no done. With en restored, a new code is accepted normally.
- Sweep (STROBE_SWEEP_EN): sweep_start pulse -> y steps 01,02,...,80, each 4 cycles with 2-cycle gaps. in_ready=0 throughout; a single done occurs during the 8'h80 strobe.
